// File: rtl/singcyc_periph_bus.sv
// Data-side bus for the single-cycle MIPS core: RAM, timer, LED/switch/7-seg and UART TX.
// Define PERIPH_UART_EN to compile in the UART transmitter; without it UART_TXD/UART_CON read 0.
module singcyc_periph_bus #(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLed,
  output logic [11:0] oDigit,
  output logic        oIrq,
  output logic        oUartTx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [26:0] PERIPH_BASE = 27'h200_0000;  // 0x40000000 >> 5

  typedef enum logic [2:0] {
    REG_TH, REG_TL, REG_TCON, REG_LED, REG_SWITCH, REG_DIGIT, REG_TXD, REG_UCON
  } regSel_e;

  if (CLKS_PER_BIT < 2 || (RAM_WORDS & (RAM_WORDS - 1)) != 0) begin : gBadParams
    $error("singcyc_periph_bus: RAM_WORDS must be a power of two and CLKS_PER_BIT >= 2");
  end

  // ---------------------------------------------------------------------------
  // Address decode (word addressed; byte offset is ignored)
  // ---------------------------------------------------------------------------
  logic          ramHit;
  logic          perHit;
  logic          perWr;
  logic [AW-1:0] ramIdx;
  regSel_e       regSel;
  logic          unusedAddr;

  assign ramHit     = (iAddr[31:AW+2] == '0);
  assign ramIdx     = iAddr[AW+1:2];
  assign perHit     = (iAddr[31:5] == PERIPH_BASE);
  assign regSel     = regSel_e'(iAddr[4:2]);
  assign perWr      = iMemWrite && perHit;
  assign unusedAddr = &{1'b0, iAddr[1:0]};

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  // NOTE: the RAM array is deliberately not reset; a reset would stop block-RAM
  // inference and software never relies on its power-up contents.
  always_ff @(posedge iClk) begin
    if (iMemWrite && ramHit) ram[ramIdx] <= iWrData;
  end

  // ---------------------------------------------------------------------------
  // Reloadable timer: CPU writes to TH/TL override the tick; an overflow set
  // of the status bit beats a simultaneous software clear.
  // ---------------------------------------------------------------------------
  logic [31:0] th;
  logic [31:0] tl;
  logic        tEn;
  logic        tIe;
  logic        tIrq;
  logic        tOvf;

  assign tOvf = tEn && (tl == '1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later statements in the block take priority.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      th   <= '0;
      tl   <= '0;
      tEn  <= 1'b0;
      tIe  <= 1'b0;
      tIrq <= 1'b0;
    end else begin
      if (tEn) tl <= tOvf ? th : tl + 32'd1;
      if (perWr && regSel == REG_TH) th <= iWrData;
      if (perWr && regSel == REG_TL) tl <= iWrData;
      if (perWr && regSel == REG_TCON) begin
        tEn <= iWrData[0];
        tIe <= iWrData[1];
        if (!iWrData[2]) tIrq <= 1'b0;
      end
      if (tOvf && tIe) tIrq <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // LED and 7-segment registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oLed   <= '0;
      oDigit <= '0;
    end else begin
      if (perWr && regSel == REG_LED)   oLed   <= iWrData[7:0];
      if (perWr && regSel == REG_DIGIT) oDigit <= iWrData[11:0];
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter (8N1)
  // ---------------------------------------------------------------------------
  logic       uartTx;
  logic       uartBusy;
  logic [7:0] uartByte;

`ifdef PERIPH_UART_EN
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uartState_e;

  uartState_e    uState;
  uartState_e    uNext;
  logic [CW-1:0] clkCnt;
  logic [2:0]    bitIdx;
  logic          bitDone;
  logic          txStart;

  assign bitDone = (clkCnt == CW'(CLKS_PER_BIT - 1));
  assign txStart = perWr && (regSel == REG_TXD) && (uState == U_IDLE);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) uState <= U_IDLE;
    else         uState <= uNext;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    uNext = uState;
    case (uState)
      U_IDLE:  if (txStart) uNext = U_START;
      U_START: if (bitDone) uNext = U_DATA;
      U_DATA:  if (bitDone && bitIdx == 3'd7) uNext = U_STOP;
      U_STOP:  if (bitDone) uNext = U_IDLE;
      default: uNext = U_IDLE;
    endcase
  end

  // Bit timer is held at zero in IDLE so START lasts exactly one bit period.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      clkCnt   <= '0;
      bitIdx   <= '0;
      uartByte <= '0;
    end else begin
      if (txStart) uartByte <= iWrData[7:0];
      if (uState == U_IDLE || bitDone) clkCnt <= '0;
      else                             clkCnt <= clkCnt + CW'(1);
      if (uState == U_START)              bitIdx <= '0;
      else if (uState == U_DATA && bitDone) bitIdx <= bitIdx + 3'd1;
    end
  end

  // Line level derives from state so reset forces the idle level without a clock.
  always_comb begin
    uartTx   = 1'b1;
    uartBusy = 1'b1;
    case (uState)
      U_IDLE:  uartBusy = 1'b0;
      U_START: uartTx   = 1'b0;
      U_DATA:  uartTx   = uartByte[bitIdx];
      default: ;
    endcase
  end
`else
  assign uartTx   = 1'b1;
  assign uartBusy = 1'b0;
  assign uartByte = '0;
`endif

  // ---------------------------------------------------------------------------
  // Combinational read path
  // ---------------------------------------------------------------------------
  logic [31:0] rdMux;

  always_comb begin
    rdMux = '0;
    if (ramHit) begin
      rdMux = ram[ramIdx];
    end else if (perHit) begin
      case (regSel)
        REG_TH:     rdMux = th;
        REG_TL:     rdMux = tl;
        REG_TCON:   rdMux = {29'd0, tIrq, tIe, tEn};
        REG_LED:    rdMux = {24'd0, oLed};
        REG_SWITCH: rdMux = {24'd0, iSwitch};
        REG_DIGIT:  rdMux = {20'd0, oDigit};
        REG_TXD:    rdMux = {24'd0, uartByte};
        REG_UCON:   rdMux = {31'd0, uartBusy};
        default:    rdMux = '0;
      endcase
    end
  end

  assign oRdData = iMemRead ? rdMux : '0;
  assign oIrq    = tIrq;
  assign oUartTx = uartTx;

endmodule

// File: tb/tb_singcyc_periph_bus.sv
// Self-checking bench for singcyc_periph_bus: directed steps plus random bus traffic
// compared against a behavioural model of the register map, timer and UART frame.
module tb_singcyc_periph_bus;

  localparam int RAM_WORDS = 256;
  localparam int CPB       = 4;

  localparam logic [31:0] A_TH    = 32'h4000_0000;
  localparam logic [31:0] A_TL    = 32'h4000_0004;
  localparam logic [31:0] A_TCON  = 32'h4000_0008;
  localparam logic [31:0] A_LED   = 32'h4000_000C;
  localparam logic [31:0] A_SW    = 32'h4000_0010;
  localparam logic [31:0] A_DIGIT = 32'h4000_0014;
  localparam logic [31:0] A_TXD   = 32'h4000_0018;
  localparam logic [31:0] A_UCON  = 32'h4000_001C;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [31:0] iAddr = '0;
  logic        iMemRead = 1'b0;
  logic        iMemWrite = 1'b0;
  logic [31:0] iWrData = '0;
  logic [7:0]  iSwitch = '0;
  logic [31:0] oRdData;
  logic [7:0]  oLed;
  logic [11:0] oDigit;
  logic        oIrq;
  logic        oUartTx;

  always #5 iClk = ~iClk;

  singcyc_periph_bus #(.RAM_WORDS(RAM_WORDS), .CLKS_PER_BIT(CPB)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iAddr(iAddr), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iWrData(iWrData), .oRdData(oRdData), .iSwitch(iSwitch),
    .oLed(oLed), .oDigit(oDigit), .oIrq(oIrq), .oUartTx(oUartTx)
  );

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] lastRd;
  logic        lastTx;

  // Reference model state; mUartCyc is the cycle count into the current frame, -1 when idle.
  logic [31:0] mRam [RAM_WORDS];
  logic [31:0] mTh, mTl;
  bit          mEn, mIe, mIrq;
  logic [7:0]  mLed, mTxd;
  logic [11:0] mDigit;
  int          mUartCyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) begin
      nPass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mTh = '0; mTl = '0; mEn = 0; mIe = 0; mIrq = 0;
    mLed = '0; mTxd = '0; mDigit = '0; mUartCyc = -1;
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a, input logic rd);
    if (!rd) return '0;
    if (a < 32'(RAM_WORDS * 4)) return mRam[a >> 2];
    case (a & ~32'h3)
      A_TH:    return mTh;
      A_TL:    return mTl;
      A_TCON:  return {29'd0, mIrq, mIe, mEn};
      A_LED:   return {24'd0, mLed};
      A_SW:    return {24'd0, iSwitch};
      A_DIGIT: return {20'd0, mDigit};
      A_TXD:   return {24'd0, mTxd};
      A_UCON:  return {31'd0, mUartCyc >= 0};
      default: return '0;
    endcase
  endfunction

  // Frame position k = cycle / CPB: start bit, eight data bits LSB first, stop bit.
  function automatic logic expTx();
    int k;
    if (mUartCyc < 0) return 1'b1;
    k = mUartCyc / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return mTxd[k-1];
  endfunction

  task automatic modelStep(input logic [31:0] a, input logic wr, input logic [31:0] d);
    bit ovf, setIrq, busy;
    ovf    = mEn && (mTl == 32'hFFFF_FFFF);
    setIrq = ovf && mIe;
    busy   = (mUartCyc >= 0);
    if (mEn) mTl = ovf ? mTh : mTl + 32'd1;
    if (busy) begin
      mUartCyc++;
      if (mUartCyc == 10 * CPB) mUartCyc = -1;
    end
    if (wr) begin
      if (a < 32'(RAM_WORDS * 4)) mRam[a >> 2] = d;
      else begin
        case (a & ~32'h3)
          A_TH:    mTh = d;
          A_TL:    mTl = d;
          A_TCON:  begin mEn = d[0]; mIe = d[1]; if (!d[2]) mIrq = 0; end
          A_LED:   mLed = d[7:0];
          A_DIGIT: mDigit = d[11:0];
`ifdef PERIPH_UART_EN
          A_TXD:   if (!busy) begin mTxd = d[7:0]; mUartCyc = 0; end
`endif
          default: ;
        endcase
      end
    end
    if (setIrq) mIrq = 1;
  endtask

  // Called at posedge+1: drive, check mid-cycle, clock, advance the model.
  task automatic busCycle(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    iAddr = a; iMemRead = rd; iMemWrite = wr; iWrData = d;
    #2;
    lastRd = oRdData;
    lastTx = oUartTx;
    check($sformatf("rdata@%08h", a), oRdData, modelRead(a, rd));
    check("irq", {31'd0, oIrq}, {31'd0, mIrq});
    check("uart_tx", {31'd0, oUartTx}, {31'd0, expTx()});
    check("led", {24'd0, oLed}, {24'd0, mLed});
    check("digit", {20'd0, oDigit}, {20'd0, mDigit});
    @(posedge iClk);
    #1;
    modelStep(a, wr, d);
  endtask

  task automatic idle();
    busCycle(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int irqLat;
    modelReset();

    // Reset state visible before any clock edge
    #1;
    check("rst_tx", {31'd0, oUartTx}, 32'd1);
    check("rst_irq", {31'd0, oIrq}, 32'd0);
    check("rst_led", {24'd0, oLed}, 32'd0);
    @(negedge iClk); @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Fill RAM so every later read has a known value
    for (int i = 0; i < RAM_WORDS; i++) busCycle(32'(i * 4), 1'b0, 1'b1, $urandom);

    // RAM: byte offset ignored, out-of-window read is 0, read-during-write gives old value
    busCycle(32'h10, 1'b1, 1'b1, 32'hDEAD_BEEF);
    busCycle(32'h10, 1'b1, 1'b0, 32'h0);
    check("ram_10", lastRd, 32'hDEAD_BEEF);
    busCycle(32'h12, 1'b1, 1'b0, 32'h0);
    check("ram_12", lastRd, 32'hDEAD_BEEF);
    busCycle(32'h400, 1'b1, 1'b0, 32'h0);
    check("ram_oob", lastRd, 32'h0);

    // LED / DIGIT / SWITCH
    busCycle(A_LED, 1'b0, 1'b1, 32'h1A5);
    busCycle(A_LED, 1'b1, 1'b0, 32'h0);
    check("led_rd", lastRd, 32'hA5);
    check("led_out", {24'd0, oLed}, 32'hA5);
    busCycle(A_DIGIT, 1'b0, 1'b1, 32'hFABC);
    busCycle(A_DIGIT, 1'b1, 1'b0, 32'h0);
    check("digit_rd", lastRd, 32'hABC);
    iSwitch = 8'h3C;
    busCycle(A_SW, 1'b1, 1'b0, 32'h0);
    check("switch_rd", lastRd, 32'h3C);

    // Timer: reload and interrupt latency
    busCycle(A_TH, 1'b0, 1'b1, 32'hFFFF_FFFC);
    busCycle(A_TL, 1'b0, 1'b1, 32'hFFFF_FFFC);
    busCycle(A_TCON, 1'b0, 1'b1, 32'h3);
    irqLat = -1;
    for (int i = 1; i <= 10; i++) begin
      idle();
      if (oIrq) begin irqLat = i; break; end
    end
    check("irq_latency", 32'(irqLat), 32'd4);
    busCycle(A_TL, 1'b1, 1'b0, 32'h0);
    check("tl_after_reload", lastRd, 32'hFFFF_FFFC);
    busCycle(A_TCON, 1'b0, 1'b1, 32'h3);
    check("irq_cleared", {31'd0, oIrq}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (mTl == 32'hFFFF_FFFF) break;
      idle();
    end
    busCycle(A_TCON, 1'b0, 1'b1, 32'h3);
    check("irq_set_beats_clear", {31'd0, oIrq}, 32'd1);
    busCycle(A_TCON, 1'b0, 1'b1, 32'h0);

`ifdef PERIPH_UART_EN
    begin
      int          firstIdle;
      logic [9:0]  bits;
      busCycle(A_TXD, 1'b0, 1'b1, 32'h55);
      firstIdle = -1;
      bits = '0;
      for (int i = 0; i < 44; i++) begin
        if (i == 10) begin
          busCycle(A_TXD, 1'b1, 1'b1, 32'hFF);
          check("txd_busy_write", lastRd, 32'h55);
        end else begin
          busCycle(A_UCON, 1'b1, 1'b0, 32'h0);
          if (lastRd == 32'h0 && firstIdle < 0) firstIdle = i;
        end
        if (i % CPB == CPB / 2 && i / CPB < 10) bits[i / CPB] = lastTx;
      end
      check("uart_busy_cycles", 32'(firstIdle), 32'(10 * CPB));
      check("uart_bits", {22'd0, bits}, {22'd0, 10'b10_1010_1010});
      busCycle(A_TXD, 1'b1, 1'b0, 32'h0);
      check("txd_last", lastRd, 32'h55);
    end
`else
    busCycle(A_TXD, 1'b0, 1'b1, 32'h55);
    for (int i = 0; i < 12; i++) idle();
    busCycle(A_UCON, 1'b1, 1'b0, 32'h0);
    check("ucon_disabled", lastRd, 32'h0);
    check("tx_disabled", {31'd0, oUartTx}, 32'd1);
`endif

    // Reset mid-frame with the timer running
    busCycle(A_TH, 1'b0, 1'b1, 32'hFFFF_FFF0);
    busCycle(A_TL, 1'b0, 1'b1, 32'hFFFF_FFF0);
    busCycle(A_TCON, 1'b0, 1'b1, 32'h3);
    busCycle(A_TXD, 1'b0, 1'b1, 32'hA3);
    for (int i = 0; i < 20; i++) idle();
    check("pre_rst_irq", {31'd0, oIrq}, 32'd1);
    iRst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, oUartTx}, 32'd1);
    check("async_rst_irq", {31'd0, oIrq}, 32'd0);
    check("async_rst_led", {24'd0, oLed}, 32'd0);
    modelReset();
    @(negedge iClk); @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    for (int i = 0; i < 8; i++) busCycle(A_TH + 32'(i * 4), 1'b1, 1'b0, 32'h0);
    busCycle(A_TCON, 1'b1, 1'b0, 32'h0);
    check("post_rst_tcon", lastRd, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int          sel;
      logic [31:0] a, d;
      logic        rd, wr;
      sel = $urandom_range(0, 11);
      d   = $urandom;
      if (sel <= 2) a = {22'd0, 8'($urandom), 2'($urandom)};
      else if (sel <= 10) a = 32'h4000_0000 + 32'((sel - 3) * 4) + 32'($urandom_range(0, 3));
      else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h4000_0020 + 32'($urandom_range(0, 31));
          1:       a = 32'h0000_0400 + 32'($urandom_range(0, 255));
          default: a = 32'h8000_0000;
        endcase
      end
      if ((sel == 3 || sel == 4) && $urandom_range(0, 1) == 1) d = {28'hFFF_FFFF, 4'($urandom)};
      if (sel == 5) d = 32'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      iSwitch = 8'($urandom);
      busCycle(a, rd, wr, d);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/singcyc_periph_bus.md
# singcyc_periph_bus

Memory-mapped data-side bus for the single-cycle MIPS core. It sits directly downstream of the core's data-memory port and consumes the core's memory address, read/write strobes and write data. It returns read data in the same cycle, as the single-cycle datapath requires. It contains the data RAM, a reloadable timer with interrupt, LED/switch/7-segment registers and an 8N1 UART transmitter.

## Interface
- `RAM_WORDS`, default 256, data RAM depth in 32-bit words; power of two.
- `CLKS_PER_BIT`, default 434, UART bit period in `iClk` cycles (50 MHz / 115200); must be ≥ 2.
- `iClk`  in  1  system clock, the same clock as the core.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iAddr`  in  32  byte address, driven by core `oRdWrMemAddr`.
- `iMemRead`  in  1  read strobe.
- `iMemWrite`  in  1  write strobe; takes effect at the rising edge of `iClk`.
- `iWrData`  in  32  write data.
- `oRdData`  out  32  read data, combinational; drives core `iRdData`.
- `iSwitch`  in  8  board switches, sampled combinationally on read.
- `oLed`  out  8  LED register.
- `oDigit`  out  12  7-segment register: [11:8] anode select, [7:0] segments.
- `oIrq`  out  1  timer interrupt; equals TCON[2].
- `oUartTx`  out  1  UART serial output; idles high.

## Operation
- Decode uses word addressing; `iAddr[1:0]` is ignored.
- RAM window: 0x00000000 up to RAM_WORDS*4−1. The RAM is indexed by `iAddr[log2(RAM_WORDS)+1:2]`.
- Peripheral registers:
  - 0x40000000 TH, R/W: timer reload value.
  - 0x40000004 TL, R/W: timer count.
  - 0x40000008 TCON, R/W [2:0]:
    - bit0: timer enable.
    - bit1: interrupt enable.
    - bit2: interrupt status, sticky. Writing 0 clears it. Writing 1 has no effect.
  - 0x4000000C LED, R/W [7:0].
  - 0x40000010 SWITCH, R/O [7:0].
  - 0x40000014 DIGIT, R/W [11:0].
  - 0x40000018 UART_TXD, W: low byte starts a transmission. Read returns the last byte accepted.
  - 0x4000001C UART_CON, R/O: bit0 is busy.
- Unused register bits read 0. Unmapped addresses read 0 and ignore writes.
- When `iMemRead` is low, `oRdData` = 0.
- Timer, each cycle that TCON[0] = 1:
  - If TL = 0xFFFFFFFF: TL ← TH. If TCON[1] is also 1, TCON[2] ← 1.
  - Otherwise: TL ← TL + 1, with 32-bit wrap-free increment.
- UART FSM states:
  - IDLE: `oUartTx` = 1. A write to UART_TXD latches the byte and moves to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive 8 bits, LSB first, CLKS_PER_BIT cycles each. A 3-bit index counts the bits.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE.
  - Busy = 1 in every state except IDLE.
- Simultaneous events:
  - A CPU write to TL or TH in the same cycle as a timer tick or reload: the CPU write wins.
  - A TCON write clearing bit2 in the same cycle as an overflow that would set it: the set wins, so no interrupt is lost.
  - A UART_TXD write while busy is ignored. The frame in progress and the latched byte are unchanged.
  - `iMemRead` and `iMemWrite` both high: the read returns the pre-write value.

## Timing
- Reads are combinational, with 0-cycle latency.
- Writes are visible to a read in the cycle after the rising edge of `iClk`.
- Timer reload period is (0xFFFFFFFF − TH + 1) cycles. TCON[2] rises on the edge that performs the reload.
- UART: `oUartTx` falls on the first edge after the accepting write. The frame lasts 10×CLKS_PER_BIT cycles. Busy clears on the edge that ends the stop bit. A new write is accepted in the cycle after that.
- Reset values:
  - `oLed` = 0, `oDigit` = 0, `oIrq` = 0, `oUartTx` = 1.
  - TH, TL, TCON, UART_TXD = 0. UART FSM = IDLE.
  - RAM contents are not reset.
- Reset asserted mid-frame aborts the transmission: `oUartTx` goes to 1 immediately, without waiting for a clock.

## Configuration
- `PERIPH_UART_EN`
  - Defined: the UART transmitter is compiled in as specified above.
  - Undefined: UART logic is absent. UART_TXD and UART_CON read 0, writes to them are ignored, and `oUartTx` is tied to 1. The `CLKS_PER_BIT` parameter remains present but is unused.

## Test plan
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000012 → both return 0xDEADBEEF. Read 0x00000400 with RAM_WORDS = 256 → 0.
- Timer: TH = 0xFFFFFFFC, TL = 0xFFFFFFFC, TCON = 3.
  - → `oIrq` rises 4 cycles after the TCON write; TL reads 0xFFFFFFFC on the following cycle.
  - Write TCON = 3 → `oIrq` falls.
  - Clear coinciding with an overflow → `oIrq` stays 1.
- LED/DIGIT/SWITCH: write LED = 0x1A5, then read → 0xA5 and `oLed` = 0xA5. With `iSwitch` = 0x3C, reading 0x40000010 → 0x3C.
- UART (CLKS_PER_BIT = 4): write 0x55 to UART_TXD → `oUartTx` sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. UART_CON = 1 for 40 cycles, then 0. A second write of 0xFF at cycle 10 is ignored.
- Reset: assert `iRst_n` low mid-frame with the timer running → `oUartTx` = 1 and `oIrq` = 0 without waiting for a clock; all registers read reset values after release.
- Build with `PERIPH_UART_EN` undefined: write 0x55 to UART_TXD → `oUartTx` stays 1 and UART_CON reads 0.
